// File: rtl/filter_mem_pkg.sv
// filter_mem_pkg: shared constants and types for the filter memory responder.
//   DEFAULT_* : default region bases and depth (24-bit entries per region)
//   REGION_BYTES : bytes per region at the default depth
//   load_state_e : coefficient loader states
//   rd_src_e : which source feeds the registered read byte
//   coeff_byte() : little-endian byte select from a 24-bit coefficient
package filter_mem_pkg;

  localparam int          DEFAULT_FILTER_DEPTH = 256;
  localparam logic [15:0] DEFAULT_SAMPLE_ADDR  = 16'h0000;
  localparam logic [15:0] DEFAULT_FILTER_ADDR  = 16'h8000;
  localparam int          REGION_BYTES         = 3 * DEFAULT_FILTER_DEPTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B0   = 2'd1,
    B1   = 2'd2,
    B2   = 2'd3
  } load_state_e;

  typedef enum logic [1:0] {
    RD_ZERO   = 2'd0,
    RD_SAMPLE = 2'd1,
    RD_COEFF  = 2'd2,
    RD_WRITE  = 2'd3
  } rd_src_e;

  function automatic logic [7:0] coeff_byte(input logic [23:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/filter_mem_if.sv
// filter_mem_if: initiator/host side signals of the filter memory responder.
//   MemAddr, MemWrite           : byte bus address and direction (initiator)
//   LoadValid/LoadReady/LoadAddr/LoadCoeff : host coefficient loader handshake
//   SampleStrobe, SampleWord    : completed 3-byte sample write report
// The bidirectional MemData byte stays a plain inout port on the responder so
// the tri-state net is resolved at the module boundary.
interface filter_mem_if;
  logic [15:0] MemAddr;
  logic        MemWrite;
  logic        LoadValid;
  logic        LoadReady;
  logic [15:0] LoadAddr;
  logic [23:0] LoadCoeff;
  logic        SampleStrobe;
  logic [23:0] SampleWord;

  modport master (
    output MemAddr, MemWrite, LoadValid, LoadAddr, LoadCoeff,
    input  LoadReady, SampleStrobe, SampleWord
  );

  modport slave (
    input  MemAddr, MemWrite, LoadValid, LoadAddr, LoadCoeff,
    output LoadReady, SampleStrobe, SampleWord
  );
endinterface

// File: rtl/byte_ram_1r1w.sv
// byte_ram_1r1w: byte-wide RAM, one synchronous write and one synchronous read
// port. A read of the address being written on the same edge returns the old
// contents. Contents are not reset.
//   clk          : clock
//   we/waddr/wdata : write port
//   raddr/rdata  : read port, rdata valid one edge after raddr
module byte_ram_1r1w #(
  parameter int DEPTH = 768,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port, read-before-write on a same-address collision
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/filter_mem_responder.sv
// filter_mem_responder: responder end of the filter byte bus. Holds the sample
// region and the coefficient region, serves byte reads (one-edge latency) and
// writes, serialises host coefficient words into bytes, and reports completed
// 3-byte sample writes.
//   Clock   : MemClk from the initiator, all state on rising edge
//   Reset   : asynchronous, active-low
//   bus     : filter_mem_if slave modport (address, direction, loader, sample)
//   MemData : bidirectional byte bus, driven only while MemWrite=0
module filter_mem_responder
  import filter_mem_pkg::*;
#(
  parameter int          FILTER_DEPTH = DEFAULT_FILTER_DEPTH,
  parameter logic [15:0] SAMPLE_ADDR  = DEFAULT_SAMPLE_ADDR,
  parameter logic [15:0] FILTER_ADDR  = DEFAULT_FILTER_ADDR
) (
  input  logic           Clock,
  input  logic           Reset,
  filter_mem_if.slave    bus,
  inout  wire  [7:0]     MemData
);

  localparam int          REGION_LEN = 3 * FILTER_DEPTH;
  localparam int          AW         = $clog2(REGION_LEN);
  localparam logic [15:0] REGION_LIM = 16'(REGION_LEN);

  logic [15:0] s_off_s, c_off_s;
  logic        s_hit_s, c_hit_s;
  logic        bus_swr_s, bus_cwr_s;
  logic [7:0]  wr_byte_s;

  load_state_e state_r, state_nxt_s;
  logic        accept_s, ld_fire_s, ld_we_s;
  logic [1:0]  ld_k_s;
  logic [15:0] ld_addr_r, ld_off_s;
  logic [23:0] ld_coeff_r;
  logic        load_ready_r;

  logic          c_we_s;
  logic [AW-1:0] c_waddr_s;
  logic [7:0]    c_wdata_s;
  logic [7:0]    s_rdata_s, c_rdata_s;

  rd_src_e     rd_src_r;
  logic [7:0]  wr_byte_r, rd_data_s;

  logic [1:0]  mask_r;
  logic [15:0] stage_r;
  logic [23:0] sample_word_r;
  logic        sample_strobe_r;

  assign wr_byte_s = MemData;

  // Address decode: 16-bit wrapping offsets, so addresses below a base miss
  always_comb begin
    s_off_s   = bus.MemAddr - SAMPLE_ADDR;
    c_off_s   = bus.MemAddr - FILTER_ADDR;
    s_hit_s   = (s_off_s < REGION_LIM);
    c_hit_s   = (c_off_s < REGION_LIM) && !s_hit_s;
    bus_swr_s = bus.MemWrite && s_hit_s;
    bus_cwr_s = bus.MemWrite && c_hit_s;
  end

  // Loader next-state: each byte state holds while a bus coefficient write owns the port
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    ld_fire_s   = 1'b0;
    ld_k_s      = 2'd0;
    case (state_r)
      IDLE: begin
        if (bus.LoadValid) begin
          accept_s    = 1'b1;
          state_nxt_s = B0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      B0: begin
        ld_k_s = 2'd0;
        if (bus_cwr_s) begin
          state_nxt_s = B0;
        end else begin
          ld_fire_s   = 1'b1;
          state_nxt_s = B1;
        end
      end
      B1: begin
        ld_k_s = 2'd1;
        if (bus_cwr_s) begin
          state_nxt_s = B1;
        end else begin
          ld_fire_s   = 1'b1;
          state_nxt_s = B2;
        end
      end
      B2: begin
        ld_k_s = 2'd2;
        if (bus_cwr_s) begin
          state_nxt_s = B2;
        end else begin
          ld_fire_s   = 1'b1;
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Loader target offset; an out-of-range byte is dropped but the FSM still advances
  assign ld_off_s = ld_addr_r + {14'd0, ld_k_s};
  assign ld_we_s  = ld_fire_s && (ld_off_s < REGION_LIM);

  // Loader state, captured request and ready flag
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r      <= IDLE;
      ld_addr_r    <= 16'h0000;
      ld_coeff_r   <= 24'h000000;
      load_ready_r <= 1'b1;
    end else begin
      state_r      <= state_nxt_s;
      load_ready_r <= (state_nxt_s == IDLE);
      if (accept_s) begin
        ld_addr_r  <= bus.LoadAddr;
        ld_coeff_r <= bus.LoadCoeff;
      end
    end
  end

  // Coefficient RAM write port: bus write has priority over the loader
  always_comb begin
    if (bus_cwr_s) begin
      c_we_s    = 1'b1;
      c_waddr_s = c_off_s[AW-1:0];
      c_wdata_s = wr_byte_s;
    end else begin
      c_we_s    = ld_we_s;
      c_waddr_s = ld_off_s[AW-1:0];
      c_wdata_s = coeff_byte(ld_coeff_r, ld_k_s);
    end
  end

  byte_ram_1r1w #(.DEPTH(REGION_LEN), .AW(AW)) u_sample_ram (
    .clk   (Clock),
    .we    (bus_swr_s),
    .waddr (s_off_s[AW-1:0]),
    .wdata (wr_byte_s),
    .raddr (s_off_s[AW-1:0]),
    .rdata (s_rdata_s)
  );

  byte_ram_1r1w #(.DEPTH(REGION_LEN), .AW(AW)) u_coeff_ram (
    .clk   (Clock),
    .we    (c_we_s),
    .waddr (c_waddr_s),
    .wdata (c_wdata_s),
    .raddr (c_off_s[AW-1:0]),
    .rdata (c_rdata_s)
  );

  // Remember which source the read byte comes from; writes echo the written byte
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rd_src_r  <= RD_ZERO;
      wr_byte_r <= 8'h00;
    end else if (bus.MemWrite) begin
      rd_src_r  <= RD_WRITE;
      wr_byte_r <= wr_byte_s;
    end else if (s_hit_s) begin
      rd_src_r  <= RD_SAMPLE;
    end else if (c_hit_s) begin
      rd_src_r  <= RD_COEFF;
    end else begin
      rd_src_r  <= RD_ZERO;
    end
  end

  // Registered read byte selection
  always_comb begin
    case (rd_src_r)
      RD_SAMPLE: rd_data_s = s_rdata_s;
      RD_COEFF:  rd_data_s = c_rdata_s;
      RD_WRITE:  rd_data_s = wr_byte_r;
      default:   rd_data_s = 8'h00;
    endcase
  end

  assign MemData = bus.MemWrite ? 8'hzz : rd_data_s;

  // Sample tracking: mask holds bytes 0/1 seen since the last +0 write
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mask_r          <= 2'b00;
      stage_r         <= 16'h0000;
      sample_word_r   <= 24'h000000;
      sample_strobe_r <= 1'b0;
    end else begin
      sample_strobe_r <= 1'b0;
      if (bus_swr_s) begin
        case (s_off_s)
          16'd0: begin
            stage_r[7:0] <= wr_byte_s;
            mask_r       <= 2'b01;
          end
          16'd1: begin
            stage_r[15:8] <= wr_byte_s;
            mask_r[1]     <= 1'b1;
          end
          16'd2: begin
            if (mask_r == 2'b11) begin
              sample_word_r   <= {wr_byte_s, stage_r};
              sample_strobe_r <= 1'b1;
              mask_r          <= 2'b00;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.LoadReady    = load_ready_r;
  assign bus.SampleStrobe = sample_strobe_r;
  assign bus.SampleWord   = sample_word_r;

endmodule

// File: tb/tb_filter_mem_responder.sv
// tb_filter_mem_responder: table-driven, directed and randomized checks of the
// filter memory responder against a byte-array reference model.
module tb_filter_mem_responder;

  logic clk;
  logic rst_n;
  logic drv_en;
  logic [7:0] drv_data;
  wire  [7:0] mem_data;

  int checks;
  int failures;

  filter_mem_if bus();

  filter_mem_responder dut (
    .Clock   (clk),
    .Reset   (rst_n),
    .bus     (bus),
    .MemData (mem_data)
  );

  assign mem_data = drv_en ? drv_data : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup (mem_data[i]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
    logic        exp_stb;
    logic [23:0] exp_word;
  } vec_t;

  vec_t vecs[18];

  // reference model state
  logic [7:0]  sm [768];
  logic [7:0]  cm [768];
  bit          mg0, mg1;
  logic [7:0]  mb0, mb1;
  logic [23:0] mword;

  logic [15:0] pool [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_op(input logic we, input logic [15:0] addr, input logic [7:0] d);
    bus.MemWrite = we;
    bus.MemAddr  = addr;
    drv_en       = we;
    drv_data     = d;
    tick();
  endtask

  // Apply one bus op and compare with the byte-array model
  task automatic model_op(input logic we, input logic [15:0] addr, input logic [7:0] d);
    int so, co;
    bit sh, ch, stb;
    logic [7:0] exp_rd;
    so = (int'(addr) - 0) & 16'hFFFF;
    co = (int'(addr) - 32'h8000) & 16'hFFFF;
    sh = (so < 768);
    ch = !sh && (co < 768);
    stb = 1'b0;
    exp_rd = 8'h00;
    if (we) begin
      if (sh) sm[so] = d;
      else if (ch) cm[co] = d;
      if (sh && so == 0) begin mg0 = 1'b1; mg1 = 1'b0; mb0 = d; end
      if (sh && so == 1) begin mg1 = 1'b1; mb1 = d; end
      if (sh && so == 2 && mg0 && mg1) begin
        stb = 1'b1; mword = {d, mb1, mb0}; mg0 = 1'b0; mg1 = 1'b0;
      end
    end else begin
      exp_rd = sh ? sm[so] : (ch ? cm[co] : 8'h00);
    end
    bus_op(we, addr, d);
    if (!we) check("rand_read", {24'h0, mem_data}, {24'h0, exp_rd});
    check("rand_strobe", {31'h0, bus.SampleStrobe}, {31'h0, stb});
    check("rand_word", {8'h0, bus.SampleWord}, {8'h0, mword});
  endtask

  initial begin
    int low;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    drv_en = 1'b0;
    drv_data = 8'h00;
    bus.MemAddr = 16'h0000;
    bus.MemWrite = 1'b0;
    bus.LoadValid = 1'b0;
    bus.LoadAddr = 16'h0000;
    bus.LoadCoeff = 24'h0;

    vecs[0]  = '{1'b1, 16'h0000, 8'h11, 8'h00, 1'b0, 24'h000000};
    vecs[1]  = '{1'b1, 16'h0001, 8'h22, 8'h00, 1'b0, 24'h000000};
    vecs[2]  = '{1'b1, 16'h0002, 8'h33, 8'h00, 1'b1, 24'h332211};
    vecs[3]  = '{1'b0, 16'h0001, 8'h00, 8'h22, 1'b0, 24'h332211};
    vecs[4]  = '{1'b0, 16'h0300, 8'h00, 8'h00, 1'b0, 24'h332211};
    vecs[5]  = '{1'b1, 16'h0300, 8'hEE, 8'h00, 1'b0, 24'h332211};
    vecs[6]  = '{1'b0, 16'h0300, 8'h00, 8'h00, 1'b0, 24'h332211};
    vecs[7]  = '{1'b0, 16'h0002, 8'h00, 8'h33, 1'b0, 24'h332211};
    vecs[8]  = '{1'b1, 16'h0002, 8'h44, 8'h00, 1'b0, 24'h332211};
    vecs[9]  = '{1'b0, 16'h0002, 8'h00, 8'h44, 1'b0, 24'h332211};
    vecs[10] = '{1'b0, 16'hFFFF, 8'h00, 8'h00, 1'b0, 24'h332211};
    vecs[11] = '{1'b1, 16'h0001, 8'h55, 8'h00, 1'b0, 24'h332211};
    vecs[12] = '{1'b1, 16'h0002, 8'h66, 8'h00, 1'b0, 24'h332211};
    vecs[13] = '{1'b1, 16'h0000, 8'h77, 8'h00, 1'b0, 24'h332211};
    vecs[14] = '{1'b1, 16'h0001, 8'h88, 8'h00, 1'b0, 24'h332211};
    vecs[15] = '{1'b1, 16'h0002, 8'h99, 8'h00, 1'b1, 24'h998877};
    vecs[16] = '{1'b0, 16'h0000, 8'h00, 8'h77, 1'b0, 24'h998877};
    vecs[17] = '{1'b0, 16'h0002, 8'h00, 8'h99, 1'b0, 24'h998877};

    pool = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h02FE, 16'h02FF,
             16'h0300, 16'h8000, 16'h8001, 16'h8002, 16'h82FF, 16'h8300, 16'h7FFF};

    // reset state
    #12;
    check("rst_ready", {31'h0, bus.LoadReady}, 32'h1);
    check("rst_strobe", {31'h0, bus.SampleStrobe}, 32'h0);
    check("rst_word", {8'h0, bus.SampleWord}, 32'h0);
    check("rst_memdata", {24'h0, mem_data}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // table vectors
    for (int i = 0; i < 18; i++) begin
      bus_op(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      if (!vecs[i].we) check($sformatf("vec%0d_rd", i), {24'h0, mem_data}, {24'h0, vecs[i].exp_rd});
      check($sformatf("vec%0d_stb", i), {31'h0, bus.SampleStrobe}, {31'h0, vecs[i].exp_stb});
      check($sformatf("vec%0d_word", i), {8'h0, bus.SampleWord}, {8'h0, vecs[i].exp_word});
    end

    // responder must not drive while MemWrite=1 (pull-up shows through)
    bus_op(1'b0, 16'h0001, 8'h00);
    check("pre_z_read", {24'h0, mem_data}, 32'h88);
    bus.MemWrite = 1'b1;
    bus.MemAddr  = 16'h0300;
    drv_en       = 1'b0;
    #1;
    check("z_before_edge", {24'h0, mem_data}, 32'hFF);
    tick();
    check("z_after_edge", {24'h0, mem_data}, 32'hFF);

    // loader: LoadAddr=3, coefficient 0xABCDEF, ready low 3 cycles
    bus.LoadAddr = 16'd3;
    bus.LoadCoeff = 24'hABCDEF;
    bus.LoadValid = 1'b1;
    bus_op(1'b0, 16'h0000, 8'h00);
    bus.LoadValid = 1'b0;
    low = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.LoadReady) break;
      low++;
      tick();
    end
    check("load_low_cycles", low, 32'd3);
    bus_op(1'b0, 16'h8003, 8'h00);
    check("load_b0", {24'h0, mem_data}, 32'hEF);
    bus_op(1'b0, 16'h8004, 8'h00);
    check("load_b1", {24'h0, mem_data}, 32'hCD);
    bus_op(1'b0, 16'h8005, 8'h00);
    check("load_b2", {24'h0, mem_data}, 32'hAB);

    // bus write in the B1 cycle stalls the loader
    bus_op(1'b1, 16'h8004, 8'h00);
    bus.LoadValid = 1'b1;
    bus_op(1'b0, 16'h0000, 8'h00);
    bus.LoadValid = 1'b0;
    check("stall_accept_ready", {31'h0, bus.LoadReady}, 32'h0);
    bus_op(1'b0, 16'h0000, 8'h00);
    bus_op(1'b1, 16'h8004, 8'h5A);
    check("stall_ready_b1", {31'h0, bus.LoadReady}, 32'h0);
    bus_op(1'b0, 16'h8004, 8'h00);
    check("stall_read_old", {24'h0, mem_data}, 32'h5A);
    check("stall_ready_b2", {31'h0, bus.LoadReady}, 32'h0);
    bus_op(1'b0, 16'h8004, 8'h00);
    check("stall_final", {24'h0, mem_data}, 32'hCD);
    check("stall_ready_idle", {31'h0, bus.LoadReady}, 32'h1);

    // asynchronous reset in B1
    bus_op(1'b1, 16'h0000, 8'hA1);
    bus.LoadCoeff = 24'h112233;
    bus.LoadValid = 1'b1;
    bus_op(1'b0, 16'h0000, 8'h00);
    bus.LoadValid = 1'b0;
    bus_op(1'b0, 16'h0000, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", {31'h0, bus.LoadReady}, 32'h1);
    check("arst_strobe", {31'h0, bus.SampleStrobe}, 32'h0);
    check("arst_word", {8'h0, bus.SampleWord}, 32'h0);
    check("arst_memdata", {24'h0, mem_data}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus_op(1'b0, 16'h8003, 8'h00);
    check("arst_8003", {24'h0, mem_data}, 32'h33);
    bus_op(1'b0, 16'h8004, 8'h00);
    check("arst_8004", {24'h0, mem_data}, 32'hCD);
    bus_op(1'b0, 16'h8005, 8'h00);
    check("arst_8005", {24'h0, mem_data}, 32'hAB);
    check("arst_ready_after", {31'h0, bus.LoadReady}, 32'h1);
    bus_op(1'b1, 16'h0001, 8'h01);
    check("arst_mask_b1", {31'h0, bus.SampleStrobe}, 32'h0);
    bus_op(1'b1, 16'h0002, 8'h02);
    check("arst_mask_b2", {31'h0, bus.SampleStrobe}, 32'h0);
    check("arst_mask_word", {8'h0, bus.SampleWord}, 32'h0);

    // randomized bus traffic against the model
    mg0 = 1'b0;
    mg1 = 1'b0;
    mb0 = 8'h00;
    mb1 = 8'h00;
    mword = 24'h000000;
    for (int i = 0; i < 14; i++) model_op(1'b1, pool[i], 8'($urandom));
    for (int i = 0; i < 400; i++) begin
      model_op(1'($urandom_range(0, 1)), pool[$urandom_range(0, 13)], 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
